sync_fifo: RTL



---
 rtl/sync_fifo.sv | 105 ++++++++++
 1 files changed

// File: rtl/sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO, 2^AW x N, wrap-bit pointers, fill count,
//            almost-full/almost-empty flags and overflow/underflow pulses.
//            Define SYNC_FIFO_FWFT_EN for first-word-fall-through output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int N      = 8,
    parameter int AW     = 3,
    parameter int AF_LVL = 6,
    parameter int AE_LVL = 2
) (
    input  logic          clk,
    input  logic          arst,
    input  logic [N-1:0]  data_in,
    input  logic          w_en,
    input  logic          r_en,
    output logic [N-1:0]  data_o,
    output logic          Full,
    output logic          Empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow
);

    localparam int          DEPTH = 1 << AW;
    localparam logic [AW:0] C_AF  = (AW+1)'(AF_LVL);
    localparam logic [AW:0] C_AE  = (AW+1)'(AE_LVL);

    logic [N-1:0] mem [DEPTH];

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         overflow_q, overflow_d;
    logic         underflow_q, underflow_d;
    logic         w_acc;
    logic         r_acc;

    // Status is a pure function of the registered pointers.
    assign count        = wr_ptr_q - rd_ptr_q;
    assign Empty        = (wr_ptr_q == rd_ptr_q);
    assign Full         = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                          (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign almost_full  = (count >= C_AF);
    assign almost_empty = (count <= C_AE);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign w_acc = w_en && !Full;
    assign r_acc = r_en && !Empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = w_en && Full;
        underflow_d = r_en && Empty;
        if (w_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        if (r_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset; resetting the pointers hides it.
    always_ff @(posedge clk) begin
        if (w_acc) mem[wr_ptr_q[AW-1:0]] <= data_in;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign data_o = mem[rd_ptr_q[AW-1:0]];
`else
    logic [N-1:0] data_o_q, data_o_d;

    always_comb begin
        data_o_d = data_o_q;
        if (r_acc) data_o_d = mem[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) data_o_q <= '0;
        else       data_o_q <= data_o_d;
    end

    assign data_o = data_o_q;
`endif

endmodule

`default_nettype wire
